// File: rtl/band_frame_pkg.sv
// Shared defaults, slot geometry and tracker state type for the band frame collector.
// Optional feature macro used by the collector: BAND_FRAME_SUM_EN.
package band_frame_pkg;

  localparam int unsigned DEF_DATA_W         = 16;
  localparam int unsigned DEF_NUM_BANDS      = 8;
  localparam int unsigned DEF_CAPTURE_OFFSET = 7;
  localparam int unsigned SLOT_COUNT         = 64;
  localparam int unsigned SLOT_W             = 6;
  localparam int unsigned BAND_WINDOW        = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } slot_state_e;

  // Slot index at which band k is valid on the multiplexed filter output.
  function automatic logic [SLOT_W-1:0] band_slot(input int unsigned k,
                                                  input int unsigned offset);
    return SLOT_W'(BAND_WINDOW * k + offset);
  endfunction

endpackage

// File: rtl/band_slot_tracker.sv
// Tracks the 64-slot band frame position against phase_0 and reports lock and alignment loss.
module band_slot_tracker
  import band_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clk_enable,
  input  logic              i_phase_0,
  output logic [SLOT_W-1:0] o_count,
  output logic              o_capture_ok_c,
  output logic              o_sync_err_c,
  output logic              o_locked,
  output logic              o_sync_err
);

  slot_state_e       r_state;
  logic [SLOT_W-1:0] r_count;
  logic              w_count_zero;

  assign w_count_zero = (r_count == '0);

  // Misalignment: phase_0 must coincide exactly with the local slot 0.
  assign o_sync_err_c   = i_clk_enable && (r_state == LOCKED) && (w_count_zero != i_phase_0);
  assign o_capture_ok_c = i_clk_enable && (r_state == LOCKED) && !o_sync_err_c;
  assign o_count        = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_count    <= '0;
      o_locked   <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      o_sync_err <= 1'b0;
      case (r_state)
        HUNT: begin
          if (i_clk_enable && i_phase_0) begin
            r_count  <= SLOT_W'(1);
            r_state  <= LOCKED;
            o_locked <= 1'b1;
          end else begin
            r_count <= '0;
          end
        end
        LOCKED: begin
          if (o_sync_err_c) begin
            r_count    <= '0;
            r_state    <= HUNT;
            o_locked   <= 1'b0;
            o_sync_err <= 1'b1;
          end else if (i_clk_enable) begin
            r_count <= r_count + SLOT_W'(1);
          end
        end
        default: begin
          r_count  <= '0;
          r_state  <= HUNT;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/band_frame_collector.sv
// Gathers time-multiplexed band results into a frame and publishes it with a valid/ready handshake.
// Defining BAND_FRAME_SUM_EN adds a registered frame_sum output (sum of the published bands).
module band_frame_collector
  import band_frame_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned NUM_BANDS      = DEF_NUM_BANDS,
  parameter int unsigned CAPTURE_OFFSET = DEF_CAPTURE_OFFSET
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic                          phase_0,
  input  logic [DATA_W-1:0]             band_data,
  input  logic                          frame_ready,
  output logic [NUM_BANDS*DATA_W-1:0]   frame_data,
  output logic                          frame_valid,
`ifdef BAND_FRAME_SUM_EN
  output logic signed [DATA_W+2:0]      frame_sum,
`endif
  output logic                          locked,
  output logic                          sync_err,
  output logic                          overrun
);

  localparam int unsigned FRAME_W = NUM_BANDS * DATA_W;

  logic [SLOT_W-1:0]  w_count;
  logic               w_capture_ok_c;
  logic               w_sync_err_c;
  logic [FRAME_W-1:0] r_work;
  logic [FRAME_W-1:0] w_next_work;
  logic               w_complete_c;

  band_slot_tracker u_tracker (
    .clk            (clk),
    .rst            (rst),
    .i_clk_enable   (clk_enable),
    .i_phase_0      (phase_0),
    .o_count        (w_count),
    .o_capture_ok_c (w_capture_ok_c),
    .o_sync_err_c   (w_sync_err_c),
    .o_locked       (locked),
    .o_sync_err     (sync_err)
  );

  // Working frame with this cycle's capture merged in; the last band completes the frame.
  always_comb begin
    w_next_work  = r_work;
    w_complete_c = 1'b0;
    if (w_capture_ok_c) begin
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
        if (w_count == band_slot(k, CAPTURE_OFFSET)) begin
          w_next_work[k*DATA_W +: DATA_W] = band_data;
          if (k == NUM_BANDS - 1) begin
            w_complete_c = 1'b1;
          end
        end
      end
    end
  end

`ifdef BAND_FRAME_SUM_EN
  localparam int unsigned SUM_W = DATA_W + 3;

  logic signed [SUM_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < NUM_BANDS; k++) begin
      w_sum = w_sum + SUM_W'(signed'(w_next_work[k*DATA_W +: DATA_W]));
    end
  end
`else
  // frame_sum and its adder are not built in this configuration.
`endif

  // A held, unaccepted frame is never overwritten; a completion that cannot load is an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef BAND_FRAME_SUM_EN
      frame_sum   <= '0;
`endif
    end else begin
      r_work <= w_sync_err_c ? '0 : w_next_work;
      if (w_complete_c) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= w_next_work;
          frame_valid <= 1'b1;
`ifdef BAND_FRAME_SUM_EN
          frame_sum   <= w_sum;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_band_frame_collector.sv
// Scoreboard bench for band_frame_collector: directed frames, sync loss, back-pressure and reset.
module tb_band_frame_collector;
  import band_frame_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NB = 8;
  localparam int unsigned FW = NB * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_enable;
  logic          phase_0;
  logic [DW-1:0] band_data;
  logic          frame_ready;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          locked;
  logic          sync_err;
  logic          overrun;
`ifdef BAND_FRAME_SUM_EN
  logic signed [DW+2:0] frame_sum;
`endif

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  band_frame_collector #(
    .DATA_W         (DW),
    .NUM_BANDS      (NB),
    .CAPTURE_OFFSET (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_enable  (clk_enable),
    .phase_0     (phase_0),
    .band_data   (band_data),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
`ifdef BAND_FRAME_SUM_EN
    .frame_sum   (frame_sum),
`endif
    .locked      (locked),
    .sync_err    (sync_err),
    .overrun     (overrun)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkf(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bval(input logic [DW-1:0] base, input logic [DW-1:0] step,
                                          input int k);
    return DW'(base + step * DW'(k));
  endfunction

  function automatic logic [FW-1:0] mkframe(input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NB; k++) f[k*DW +: DW] = bval(base, step, k);
    return f;
  endfunction

  function automatic logic [DW-1:0] slot_data(input logic [DW-1:0] base, input logic [DW-1:0] step,
                                               input int s);
    if (s % 8 == 7) return bval(base, step, s / 8);
    return DW'(32'hA5A5 ^ 32'(s));
  endfunction

`ifdef BAND_FRAME_SUM_EN
  function automatic logic signed [DW+2:0] fsum(input logic [FW-1:0] f);
    int acc;
    acc = 0;
    for (int k = 0; k < NB; k++) acc += int'($signed(f[k*DW +: DW]));
    return (DW+3)'(acc);
  endfunction
`endif

  task automatic tick(input logic en, input logic ph, input logic [DW-1:0] d, input logic rdy);
    clk_enable  = en;
    phase_0     = ph;
    band_data   = d;
    frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Issues slots 0..n-1 of a frame; n=64 runs a complete frame.
  task automatic frame(input logic [DW-1:0] base, input logic [DW-1:0] step, input int n,
                       input logic rdy, input logic rdy_last, input int gap, input logic push);
    if (push) exp_q.push_back(mkframe(base, step));
    for (int s = 0; s < n; s++) begin
      tick(1'b1, s == 0, slot_data(base, step, s), (s == 63) ? rdy_last : rdy);
      if (s == 0) check1("locked_after_phase0", locked, 1'b1);
      if (s < 63) for (int g = 0; g < gap; g++) tick(1'b0, 1'b1, DW'(16'h0BAD), rdy);
    end
  endtask

  // Monitor: a frame is presented when valid rises or a new frame replaces an accepted one.
  logic v_prev = 1'b0;
  logic r_prev = 1'b0;
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (!rst && frame_valid && (!v_prev || r_prev)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %h expected none", frame_data);
      end else begin
        e = exp_q.pop_front();
        checkf("frame_data", frame_data, e);
`ifdef BAND_FRAME_SUM_EN
        checks++;
        if (frame_sum !== fsum(e)) begin
          errors++;
          $display("FAIL frame_sum: got %0d expected %0d", frame_sum, fsum(e));
        end
`endif
      end
    end
    v_prev <= frame_valid & ~rst;
    r_prev <= frame_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clk_enable = 1'b0; phase_0 = 1'b0; band_data = '0; frame_ready = 1'b0;
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
    check1("rst_frame_valid", frame_valid, 1'b0);
    check1("rst_locked", locked, 1'b0);
    check1("rst_sync_err", sync_err, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    checkf("rst_frame_data", frame_data, '0);
    rst = 1'b0;

    // phase_0 without enable is ignored
    tick(1'b0, 1'b1, '0, 1'b1);
    tick(1'b1, 1'b0, '0, 1'b1);
    check1("hunt_no_lock", locked, 1'b0);

    // Scenario 1: aligned frames with ready high
    frame(16'h0100, 16'h0100, 64, 1'b1, 1'b1, 0, 1'b1);
    check1("s1_valid_after_slot63", frame_valid, 1'b1);
    checkf("s1_frame_data", frame_data, mkframe(16'h0100, 16'h0100));
    tick(1'b0, 1'b0, '0, 1'b1);
    check1("s1_valid_pulse_ends", frame_valid, 1'b0);
    frame(16'h1111, 16'h0101, 64, 1'b1, 1'b1, 1, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);

    // Scenario 2: phase_0 at count 40
    frame(16'h2000, 16'h0001, 40, 1'b1, 1'b1, 0, 1'b0);
    tick(1'b1, 1'b1, '0, 1'b1);
    check1("s2_sync_err", sync_err, 1'b1);
    check1("s2_unlocked", locked, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    check1("s2_sync_err_pulse", sync_err, 1'b0);
    repeat (5) tick(1'b1, 1'b0, DW'(16'h1234), 1'b1);
    check1("s2_stay_hunt", locked, 1'b0);
    frame(16'h0300, 16'h0011, 64, 1'b1, 1'b1, 0, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);

    // sync error at slot 63 beats the completion
    frame(16'h2100, 16'h0002, 63, 1'b1, 1'b1, 0, 1'b0);
    tick(1'b1, 1'b1, bval(16'h2100, 16'h0002, 7), 1'b1);
    check1("prio_sync_err", sync_err, 1'b1);
    check1("prio_no_frame", frame_valid, 1'b0);

    // Scenario 4: ready only in the cycle the second frame completes
    frame(16'h4000, 16'h0010, 64, 1'b0, 1'b0, 0, 1'b1);
    check1("s4_first_valid", frame_valid, 1'b1);
    frame(16'h5000, 16'h0020, 64, 1'b0, 1'b1, 0, 1'b1);
    check1("s4_valid_held", frame_valid, 1'b1);
    check1("s4_no_overrun", overrun, 1'b0);
    checkf("s4_second_frame", frame_data, mkframe(16'h5000, 16'h0020));
    tick(1'b0, 1'b0, '0, 1'b1);
    check1("s4_accepted", frame_valid, 1'b0);

    // Scenario 3: ready low across two completions
    frame(16'h6000, 16'h0003, 64, 1'b0, 1'b0, 0, 1'b1);
    frame(16'h7000, 16'h0005, 64, 1'b0, 1'b0, 0, 1'b0);
    check1("s3_overrun", overrun, 1'b1);
    check1("s3_valid_held", frame_valid, 1'b1);
    checkf("s3_data_held", frame_data, mkframe(16'h6000, 16'h0003));

    // Scenario 5: reset at slot 30
    frame(16'h0A00, 16'h0001, 30, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0, DW'(16'h5555), 1'b0);
    rst = 1'b0;
    check1("s5_valid", frame_valid, 1'b0);
    check1("s5_locked", locked, 1'b0);
    check1("s5_overrun", overrun, 1'b0);
    check1("s5_sync_err", sync_err, 1'b0);
    checkf("s5_frame_data", frame_data, '0);
    repeat (40) tick(1'b1, 1'b0, DW'(16'h7777), 1'b1);
    check1("s5_no_relock", locked, 1'b0);
    check1("s5_no_valid", frame_valid, 1'b0);
    frame(16'h0C00, 16'h0100, 64, 1'b1, 1'b1, 0, 1'b1);
    check1("s5_relock_frame", frame_valid, 1'b1);
    tick(1'b0, 1'b0, '0, 1'b1);

`ifdef BAND_FRAME_SUM_EN
    // Scenario 6: sum extremes
    frame(16'h7FFF, 16'h0000, 64, 1'b1, 1'b1, 0, 1'b1);
    checks++;
    if (frame_sum !== 19'sh3FFF8) begin
      errors++;
      $display("FAIL s6_sum_max: got %h expected 3fff8", frame_sum);
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    frame(16'h8000, 16'h0000, 64, 1'b1, 1'b1, 0, 1'b1);
    checks++;
    if (frame_sum !== -19'sd262144) begin
      errors++;
      $display("FAIL s6_sum_min: got %0d expected -262144", frame_sum);
    end
    tick(1'b0, 1'b0, '0, 1'b1);
`endif

    repeat (4) tick(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_outstanding: got %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/band_frame_collector.md
BAND_FRAME_COLLECTOR -- requirements
Module: band_frame_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: signed band sample width.
REQ-002 The block SHALL have parameter NUM_BANDS, default 8: band results per frame.
REQ-003 The block SHALL have parameter CAPTURE_OFFSET, default 7: slot offset within each 8-slot band window at which band data is valid.
REQ-004 The block SHALL have port clk, input, 1: single clock; one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port clk_enable, input, 1: sample-rate slot strobe, shared with the phase counter.
REQ-007 The block SHALL have port phase_0, input, 1: counter slot-0 marker, already qualified by clk_enable.
REQ-008 The block SHALL have port band_data, input, DATA_W: time-multiplexed filter output, signed.
REQ-009 The block SHALL have port frame_ready, input, 1: downstream accept.
REQ-010 The block SHALL have port frame_data, output, NUM_BANDS*DATA_W: band k in bits [k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port frame_valid, output, 1: frame_data holds a complete frame.
REQ-012 The block SHALL have port locked, output, 1: slot tracker aligned to phase_0.
REQ-013 The block SHALL have port sync_err, output, 1: one-cycle pulse on alignment loss.
REQ-014 The block SHALL have port overrun, output, 1: sticky, set when a completed frame is dropped.

Function
REQ-015 Local slot count SHALL be 6 bits (0..63), advancing only on clk_enable cycles and wrapping 63->0.
REQ-016 The FSM SHALL have two states: HUNT and LOCKED.
REQ-017 In HUNT, an enabled cycle with phase_0=1 SHALL set count to 1 and enter LOCKED; all other cycles SHALL leave count at 0 and capture nothing.
REQ-018 In LOCKED, an enabled cycle with count==0 and phase_0=0, or phase_0=1 with count!=0, SHALL pulse sync_err for one cycle, return to HUNT, zero count and discard the partial frame.
REQ-019 In LOCKED, on an enabled cycle with count==8k+CAPTURE_OFFSET (k<NUM_BANDS) and no sync error, band_data SHALL be written into working slot k.
REQ-020 The capture of band NUM_BANDS-1 (slot 63 at defaults) SHALL complete the frame; frame_valid SHALL assert on the following cycle (latency 1 clk after the final capture).
REQ-021 On completion, the working frame SHALL be copied to frame_data if frame_valid==0 or frame_ready==1 in that cycle; otherwise the new frame SHALL be dropped, frame_data SHALL be held, and overrun SHALL be set.
REQ-022 frame_valid SHALL stay high and frame_data stable until a cycle with frame_ready=1; frame_valid SHALL then deassert unless a completion loads a new frame in the same cycle.
REQ-023 A sync error SHALL take priority over a completion in the same cycle; no frame SHALL be published.
REQ-024 phase_0=1 with clk_enable=0 SHALL be ignored.
REQ-025 A completion SHALL NOT alter frame_data while frame_valid=1 and frame_ready=0.

Reset
REQ-026 While rst=1 at a clk edge: state=HUNT, count=0, working frame=0, frame_data=0, frame_valid=0, locked=0, sync_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard both the working and the output frames; relock SHALL require a new phase_0.

Configuration
REQ-028 With BAND_FRAME_SUM_EN defined, the block SHALL add output frame_sum, DATA_W+3 bits signed: the exact sum of the published bands, registered with frame_data, reset 0, stable under the same handshake.
REQ-029 Without BAND_FRAME_SUM_EN, frame_sum and its adder SHALL be absent.

Structure
REQ-030 Package band_frame_pkg SHALL hold the DATA_W/NUM_BANDS/CAPTURE_OFFSET defaults, SLOT_COUNT=64, SLOT_W=6 and the HUNT/LOCKED state enum.
REQ-031 Sub-module band_slot_tracker SHALL contain the count, FSM, locked and sync_err logic; the top SHALL contain the capture, output registers, handshake and sum.

Verification
REQ-032 Scenario 1: after reset, phase_0 every 64 enables, band k=0x0100*(k+1) at slot 8k+7, frame_ready=1 -> locked=1 after the first phase_0; frame_valid pulses 1 clk after slot 63; frame_data = {0x0800,...,0x0100}.
REQ-033 Scenario 2: phase_0 at count 40 -> sync_err one cycle, locked=0, no frame_valid for that frame; relock at the next phase_0.
REQ-034 Scenario 3: frame_ready=0 across two completions -> first frame held, overrun=1, frame_data unchanged.
REQ-035 Scenario 4: frame_ready=1 in the cycle a second frame completes -> frame_valid stays 1, frame_data updates to the second frame, overrun=0.
REQ-036 Scenario 5: rst at slot 30 -> all outputs 0 next cycle; first frame_valid only after a full frame following a new phase_0.
REQ-037 Scenario 6 (BAND_FRAME_SUM_EN): all bands 0x7FFF -> frame_sum=0x3FFF8; all bands 0x8000 -> frame_sum=-262144.
